axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Arbiter and sequencer for the single AXI3 read channel shared by the instruction fetch unit and the data unit of the memory subsystem. Accepts one read request per requester, grants the channel to one owner at a time, drives the AR handshake, and routes R beats back to the owner until `rlast`. It replaces ad-hoc combinational muxing with a registered grant that is held for the whole transaction and checked beat by beat.

## Interface

- `ID_I`, default 4'd0: `arid` value used for instruction transactions.
- `ID_D`, default 4'd1: `arid` value used for data transactions.
- `LINE_BEATS`, default 16: beats in a line burst (`arlen = LINE_BEATS-1`).

Ports. Reset is `rst`, synchronous, active-high; the clock is `clk`.

- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `i_req_valid`  in  1  instruction read request, held until `i_req_ready`
- `i_req_addr`  in  32  physical address
- `i_req_single`  in  1  1: single beat (FIXED); 0: line burst (INCR)
- `i_req_ready`  out  1  one-cycle pulse on AR handshake for this requester
- `i_rdata`  out  32  returned beat data
- `i_rvalid`  out  1  beat valid
- `i_rlast`  out  1  final beat
- `d_req_valid`, `d_req_addr`, `d_req_single`, `d_req_ready`, `d_rdata`, `d_rvalid`, `d_rlast`: same as above, for the data requester
- `arid`  out  4; `araddr`  out  32; `arlen`  out  8; `arsize`  out  3 (always 3'b010); `arburst`  out  2; `arvalid`  out  1; `arready`  in  1
- `rid`  in  4; `rdata`  in  32; `rresp`  in  2; `rlast`  in  1; `rvalid`  in  1; `rready`  out  1 (always 1)
- `busy`  out  1  asserted in any state other than IDLE
- `err`  out  1  one-cycle pulse on a protocol error (see Operation)

## Operation

- FSM states: IDLE, ADDR, DATA.
- IDLE: if any `*_req_valid` is high, pick an owner, latch its addr and type into AR registers, set `arid`, and go to ADDR. `rvalid` in IDLE is dropped: no routing, no `err`.
- Fixed priority (default): data wins over instruction when both are requesting.
- ADDR: `arvalid`=1 and AR fields stay stable. When `arready` is high, pulse the owner's `*_req_ready`, clear the beat counter, and go to DATA.
- DATA: each cycle with `rvalid` high, copy `rdata`, `rvalid` and `rlast` to the owner's outputs and increment the 8-bit beat counter. On `rvalid && rlast`, go to IDLE.
- Non-owner R outputs are held at 0 at all times.
- Single request: `arlen`=0, `arburst`=2'b00. Line request: `arlen`=LINE_BEATS-1, `arburst`=2'b01.
- `err` pulses on a beat in DATA under any of these conditions:
  - `rid` ≠ the latched `arid`;
  - `rresp` ≠ 0;
  - `rlast` arrives with counter ≠ `arlen`;
  - counter == `arlen` and `rlast` is low.
  The beat is still routed. Exit from DATA happens only on `rlast`.
- A request that deasserts before its grant is a requester bug. It is not supported.

## Timing

- Reset: state=IDLE. `arvalid`, `araddr`, `arlen`, `arburst`, `arid`, `busy`, `err`, and all `*_req_ready`/`*_rdata`/`*_rvalid`/`*_rlast` are 0. Round-robin pointer selects data first.
- Reset is honoured in any state. An in-flight transaction is abandoned, and its late beats land in IDLE and are dropped.
- Request in IDLE → `arvalid` high in the next cycle, so minimum AR latency is 1 cycle. `*_req_ready` is asserted in the cycle `arvalid && arready`.
- R routing is combinational from `rdata`/`rvalid`/`rlast` in DATA, with zero added latency.
- Back-to-back transactions: a new request seen in the cycle IDLE is re-entered gives `arvalid` in the following cycle. There is at least one IDLE cycle between transactions.
- `err` is registered: it appears 1 cycle after the offending beat.

## Configuration

- `AXI_ARB_RR_EN` defined: round-robin arbitration. When both requesters are valid in IDLE, the requester not granted last wins. The pointer updates on each grant.
- Not defined: fixed data-over-instruction priority. No pointer register.

## Test plan

- Reset: hold `rst` 2 cycles while `rvalid`=1 → all outputs 0, `busy`=0, no `err`.
- Data single read: `d_req_valid`, addr 0x0000_1000, single=1; `arready`=1 → `araddr`=0x1000, `arlen`=0, `arburst`=0, `arid`=1, `d_req_ready` pulse. One beat 0xDEADBEEF with `rlast` → `d_rdata`=0xDEADBEEF, `d_rlast`=1, `i_rvalid` stays 0.
- Instruction line read, `arready` delayed 3 cycles: `arvalid` held with stable fields. 16 beats with gaps → 16 `i_rvalid` pulses, `i_rlast` on the 16th, return to IDLE, no `err`.
- Contention: both requests valid in the same IDLE cycle, repeated twice.
  - Without the macro: data, data.
  - With `AXI_ARB_RR_EN`: data, then instruction.
- Early `rlast` on beat 5 of a line burst → `err` pulse 1 cycle later, FSM returns to IDLE.
- Wrong `rid`=2 or `rresp`=2'b10 on a single read → beat still routed, `err` pulse.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_if
// Bundle of every signal between the read arbiter, its two requesters
// (instruction fetch "i_*", data unit "d_*") and the shared AXI3 read channel.
//   master : arbiter view (drives AR, requester returns, rready)
//   slave  : environment view (requesters + AXI slave)
// Requester side : *_req_valid/addr/single in, *_req_ready, *_rdata,
//                  *_rvalid, *_rlast out (from the arbiter's point of view)
// AXI side       : arid/araddr/arlen/arsize/arburst/arvalid out, arready in;
//                  rid/rdata/rresp/rlast/rvalid in, rready out
// ---------------------------------------------------------------------------
interface axi_read_arbiter_if;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        i_req_single;
  logic        i_req_ready;
  logic [31:0] i_rdata;
  logic        i_rvalid;
  logic        i_rlast;

  logic        d_req_valid;
  logic [31:0] d_req_addr;
  logic        d_req_single;
  logic        d_req_ready;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_rlast;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    input  i_req_valid, i_req_addr, i_req_single,
    output i_req_ready, i_rdata, i_rvalid, i_rlast,
    input  d_req_valid, d_req_addr, d_req_single,
    output d_req_ready, d_rdata, d_rvalid, d_rlast,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    output i_req_valid, i_req_addr, i_req_single,
    input  i_req_ready, i_rdata, i_rvalid, i_rlast,
    output d_req_valid, d_req_addr, d_req_single,
    input  d_req_ready, d_rdata, d_rvalid, d_rlast,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
// Shares one AXI3 read channel between the instruction fetch unit and the
// data unit. One owner at a time: the grant is registered in IDLE, held
// through the AR handshake (ADDR) and the R burst (DATA), and every R beat
// is checked against the latched ID/length.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset
//   bus  : axi_read_arbiter_if.master (requesters + AXI read channel)
//   busy : high in any state other than IDLE
//   err  : one-cycle pulse, one cycle after a bad beat (ID, RESP, length)
// Configuration:
//   AXI_ARB_RR_EN defined -> round-robin between the two requesters
//   otherwise             -> fixed priority, data wins over instruction
// ---------------------------------------------------------------------------
module axi_read_arbiter #(
  parameter logic [3:0] ID_I       = 4'd0,
  parameter logic [3:0] ID_D       = 4'd1,
  parameter int         LINE_BEATS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_read_arbiter_if.master   bus,
  output logic                 busy,
  output logic                 err
);

  localparam logic [7:0] LINE_LEN = 8'(LINE_BEATS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic [1:0]  arburst_q, arburst_d;
  logic [3:0]  arid_q, arid_d;
  logic        arvalid_q, arvalid_d;
  logic        owner_is_d_q, owner_is_d_d;  // 1: data unit owns the channel
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic        err_q, err_d;
  logic        grant_d;                     // 1: data unit wins this IDLE cycle
  logic        req_single;

`ifdef AXI_ARB_RR_EN
  logic        last_was_d_q, last_was_d_d;  // reset 0 so data goes first

  assign grant_d = bus.d_req_valid && (!bus.i_req_valid || !last_was_d_q);
`else
  assign grant_d = bus.d_req_valid;
`endif

  assign req_single = grant_d ? bus.d_req_single : bus.i_req_single;

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arburst_d    = arburst_q;
    arid_d       = arid_q;
    arvalid_d    = arvalid_q;
    owner_is_d_d = owner_is_d_q;
    beat_cnt_d   = beat_cnt_q;
    err_d        = 1'b0;
`ifdef AXI_ARB_RR_EN
    last_was_d_d = last_was_d_q;
`endif
    case (state_q)
      IDLE: begin
        // Beats arriving here belong to an abandoned transaction: ignored.
        if (bus.i_req_valid || bus.d_req_valid) begin
          state_d      = ADDR;
          arvalid_d    = 1'b1;
          owner_is_d_d = grant_d;
          araddr_d     = grant_d ? bus.d_req_addr : bus.i_req_addr;
          arlen_d      = req_single ? 8'd0 : LINE_LEN;
          arburst_d    = req_single ? 2'b00 : 2'b01;
          arid_d       = grant_d ? ID_D : ID_I;
`ifdef AXI_ARB_RR_EN
          last_was_d_d = grant_d;
`endif
        end
      end
      ADDR: begin
        if (bus.arready) begin
          state_d    = DATA;
          arvalid_d  = 1'b0;
          beat_cnt_d = 8'd0;
        end
      end
      DATA: begin
        if (bus.rvalid) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          err_d = (bus.rid != arid_q) || (bus.rresp != 2'b00) ||
                  (bus.rlast && (beat_cnt_q != arlen_q)) ||
                  (!bus.rlast && (beat_cnt_q == arlen_q));
          // Only rlast ends the burst, even when the count is off.
          if (bus.rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      araddr_q     <= '0;
      arlen_q      <= '0;
      arburst_q    <= '0;
      arid_q       <= '0;
      arvalid_q    <= 1'b0;
      owner_is_d_q <= 1'b0;
      beat_cnt_q   <= '0;
      err_q        <= 1'b0;
`ifdef AXI_ARB_RR_EN
      last_was_d_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arburst_q    <= arburst_d;
      arid_q       <= arid_d;
      arvalid_q    <= arvalid_d;
      owner_is_d_q <= owner_is_d_d;
      beat_cnt_q   <= beat_cnt_d;
      err_q        <= err_d;
`ifdef AXI_ARB_RR_EN
      last_was_d_q <= last_was_d_d;
`endif
    end
  end

  // Zero-latency R routing; gated by rst so nothing leaks while resetting.
  logic beat_ok, ar_hs;
  assign beat_ok = !rst && (state_q == DATA) && bus.rvalid;
  assign ar_hs   = !rst && (state_q == ADDR) && arvalid_q && bus.arready;

  assign bus.d_rvalid    = beat_ok && owner_is_d_q;
  assign bus.d_rlast     = beat_ok && owner_is_d_q && bus.rlast;
  assign bus.d_rdata     = (beat_ok && owner_is_d_q) ? bus.rdata : 32'd0;
  assign bus.i_rvalid    = beat_ok && !owner_is_d_q;
  assign bus.i_rlast     = beat_ok && !owner_is_d_q && bus.rlast;
  assign bus.i_rdata     = (beat_ok && !owner_is_d_q) ? bus.rdata : 32'd0;
  assign bus.d_req_ready = ar_hs && owner_is_d_q;
  assign bus.i_req_ready = ar_hs && !owner_is_d_q;

  assign bus.arid    = arid_q;
  assign bus.araddr  = araddr_q;
  assign bus.arlen   = arlen_q;
  assign bus.arsize  = 3'b010;
  assign bus.arburst = arburst_q;
  assign bus.arvalid = arvalid_q;
  assign bus.rready  = 1'b1;

  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule
